// File: rtl/i2c_frame_pkg.sv
// Shared definitions for the FPGA-A I2C write engine and the FPGA-B receiver:
// frame layout, opcodes and the master FSM encoding.
package i2c_frame_pkg;
   localparam int          FRAME_BYTES = 13;
   localparam int          FRAME_BITS  = FRAME_BYTES * 8;
   localparam logic [5:0]  HEADER_MARK = 6'b111111;

   localparam logic [1:0]  OP_ADD = 2'b00;
   localparam logic [1:0]  OP_SUB = 2'b01;
   localparam logic [1:0]  OP_MUL = 2'b10;
   localparam logic [1:0]  OP_DIV = 2'b11;

   typedef enum logic [2:0] {
      IDLE, START_HOLD, START_LOW, BIT, ACK, STOP_LOW, STOP_RISE, STOP_HOLD
   } state_t;

   // Payload as it appears on the wire, MSB of mark first.
   typedef struct packed {
      logic [5:0]  mark;
      logic [1:0]  opcode;
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [31:0] ans;
   } frame_t;

   function automatic frame_t pack_frame(input logic [1:0] opcode,
                                         input logic [31:0] op_a,
                                         input logic [31:0] op_b,
                                         input logic [31:0] ans);
      frame_t f;
      f.mark   = HEADER_MARK;
      f.opcode = opcode;
      f.op_a   = op_a;
      f.op_b   = op_b;
      f.ans    = ans;
      return f;
   endfunction
endpackage

// File: rtl/i2c_frame_master_tick_gen.sv
// Quarter-bit timebase: one-clock tick every Q clocks while enabled.
module i2c_tick_gen #(
   parameter int Q = 250
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic restart,
   output logic tick
);
   localparam int W = (Q > 1) ? $clog2(Q) : 1;

   logic [W-1:0] cnt;

   assign tick = en && (cnt == W'(Q - 1));

   // Reloading on every tick keeps quarters drift-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  cnt <= '0;
      else if (restart || tick) cnt <= '0;
      else if (en)              cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/i2c_frame_master.sv
// I2C master write engine: START, address byte, 13-byte operation frame, STOP;
// aborts to STOP on the first NACK.
module i2c_frame_master
   import i2c_frame_pkg::*;
#(
   parameter int         CLK_FREQ_HZ = 100_000_000,
   parameter int         I2C_FREQ_HZ = 100_000,
   parameter logic [6:0] SLAVE_ADDR  = 7'b0000111
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  opcode,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [31:0] ans,
   output logic        busy,
   output logic        done,
   output logic        nack,
   output logic [3:0]  bytes_acked,
   inout  wire         scl,
   inout  wire         sda
);
   localparam int Q = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);

   state_t                state;
   logic [1:0]            phase;
   logic [2:0]            bit_cnt;
   logic [3:0]            byte_cnt;
   logic [FRAME_BITS+7:0] shreg;
   logic                  scl_low, sda_low, ack_ok, tick, accept;

   // busy stays high through the done cycle, so IDLE alone does not admit a start.
   assign accept = start && !busy && (state == IDLE);

   assign scl = scl_low ? 1'b0 : 1'bz;
   assign sda = sda_low ? 1'b0 : 1'bz;

   i2c_tick_gen #(.Q(Q)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .en      (state != IDLE),
      .restart (accept),
      .tick    (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         phase       <= '0;
         bit_cnt     <= '0;
         byte_cnt    <= '0;
         shreg       <= '0;
         scl_low     <= 1'b0;
         sda_low     <= 1'b0;
         ack_ok      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         nack        <= 1'b0;
         bytes_acked <= '0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            busy <= 1'b0;
            if (accept) begin
               busy        <= 1'b1;
               nack        <= 1'b0;
               bytes_acked <= '0;
               byte_cnt    <= '0;
               shreg       <= {SLAVE_ADDR, 1'b0, pack_frame(opcode, op_a, op_b, ans)};
               sda_low     <= 1'b1;
               state       <= START_HOLD;
            end
         end else if (tick) begin
            case (state)
               START_HOLD: begin
                  scl_low <= 1'b1;
                  state   <= START_LOW;
               end
               START_LOW: begin
                  sda_low <= ~shreg[FRAME_BITS+7];
                  bit_cnt <= '0;
                  phase   <= '0;
                  state   <= BIT;
               end
               BIT, ACK: begin
                  phase <= phase + 1'b1;
                  case (phase)
                     2'd0: scl_low <= 1'b0;
                     2'd1: ;
                     2'd2: begin
                        scl_low <= 1'b1;
                        if (state == ACK) begin
                           ack_ok <= !sda;
                           if (!sda && byte_cnt != 4'd0) bytes_acked <= bytes_acked + 1'b1;
                        end
                     end
                     default: begin
                        if (state == BIT) begin
                           shreg   <= {shreg[FRAME_BITS+6:0], 1'b0};
                           bit_cnt <= bit_cnt + 1'b1;
                           if (bit_cnt == 3'd7) begin
                              sda_low <= 1'b0;
                              state   <= ACK;
                           end else begin
                              sda_low <= ~shreg[FRAME_BITS+6];
                           end
                        end else if (ack_ok && byte_cnt != 4'(FRAME_BYTES)) begin
                           byte_cnt <= byte_cnt + 1'b1;
                           sda_low  <= ~shreg[FRAME_BITS+7];
                           state    <= BIT;
                        end else begin
                           sda_low <= 1'b1;
                           nack    <= ~ack_ok;
                           state   <= STOP_LOW;
                        end
                     end
                  endcase
               end
               STOP_LOW: begin
                  scl_low <= 1'b0;
                  state   <= STOP_RISE;
               end
               STOP_RISE: begin
                  sda_low <= 1'b0;
                  state   <= STOP_HOLD;
               end
               STOP_HOLD: begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
